// File: rtl/vga_pkg.sv
// Shared VGA timing constants, RGB565 field positions and pin widths for the scan-out slice.
// Defaults describe 640x480@60; modules take them as overridable parameter defaults.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int RGB565_W  = 16;
    localparam int R565_MSB  = 15;
    localparam int G565_MSB  = 10;
    localparam int B565_MSB  = 4;

    localparam int VGA_R_W = 3;
    localparam int VGA_G_W = 3;
    localparam int VGA_B_W = 2;

    typedef struct packed {
        logic [VGA_R_W-1:0] r;
        logic [VGA_G_W-1:0] g;
        logic [VGA_B_W-1:0] b;
    } vga_rgb_t;

    // Keep the most significant bits of each RGB565 field for the resistor DAC pins.
    function automatic vga_rgb_t rgb565_to_vga(input logic [RGB565_W-1:0] px);
        vga_rgb_t c;
        c.r = px[R565_MSB -: VGA_R_W];
        c.g = px[G565_MSB -: VGA_G_W];
        c.b = px[B565_MSB -: VGA_B_W];
        return c;
    endfunction

endpackage

// File: rtl/vga_scan_out_if.sv
// Pop handshake between the pixel line FIFO (slave) and the scan-out consumer (master).
interface vga_scan_out_if;
    import vga_pkg::*;

    logic                fifo_rd_en;
    logic [RGB565_W-1:0] fifo_data;
    logic                fifo_valid;

    modport master (output fifo_rd_en, input fifo_data, input fifo_valid);
    modport slave  (input fifo_rd_en, output fifo_data, output fifo_valid);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters plus the per-position strobes derived from them.
// Counters park at the first vblank line so upstream can prefetch line 0 before scan starts.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic half_clk,
    input  logic rst,
    input  logic en_i,
    output logic en_q_o,
    output logic act_o,
    output logic hs_raw_o,
    output logic vs_raw_o,
    output logic frame_start_o,
    output logic line_req_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT_C   = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C   = cnt_t'(V_ACTIVE);
    localparam cnt_t V_ACT_M1  = cnt_t'(V_ACTIVE - 1);
    localparam cnt_t HS_FIRST  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_FIRST  = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic en_q;
    cnt_t h_q, h_d;
    cnt_t v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
            end else begin
                h_d = h_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge half_clk or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
            h_q  <= '0;
            v_q  <= V_ACT_C;
        end else begin
            en_q <= en_i;
            h_q  <= h_d;
            v_q  <= v_d;
        end
    end

    assign en_q_o        = en_q;
    assign act_o         = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hs_raw_o      = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign vs_raw_o      = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    assign frame_start_o = en_q && (h_q == '0) && (v_q == V_ACT_C);
    // Request issued at the end of the line before each visible line, including the last vblank line.
    assign line_req_o    = en_q && (h_q == H_ACT_C) && ((v_q == V_LAST) || (v_q < V_ACT_M1));

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out stage: pops RGB565 pixels from the line FIFO and drives the VGA pins.
// Sync and pixel paths share a two-register pipeline so they stay aligned with the FIFO read latency.
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               half_clk,
    input  logic               rst,
    input  logic               en,
    vga_scan_out_if.master     fifo,
    output logic               frame_start,
    output logic               line_req,
    output logic               hsync,
    output logic               vsync,
    output logic [VGA_R_W-1:0] vga_red,
    output logic [VGA_G_W-1:0] vga_green,
    output logic [VGA_B_W-1:0] vga_blue,
    output logic               underflow,
    input  logic               clr_underflow
);

    logic en_q;
    logic act;
    logic hs_raw;
    logic vs_raw;
    logic rd_en;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .half_clk      (half_clk),
        .rst           (rst),
        .en_i          (en),
        .en_q_o        (en_q),
        .act_o         (act),
        .hs_raw_o      (hs_raw),
        .vs_raw_o      (vs_raw),
        .frame_start_o (frame_start),
        .line_req_o    (line_req)
    );

    assign rd_en           = en_q && act;
    assign fifo.fifo_rd_en = rd_en;

    // Stage 1 holds the gated read so a frozen scan position is not mistaken for a starved pixel.
    logic     act_d1_q;
    logic     hs_d1_q;
    logic     vs_d1_q;

    vga_rgb_t rgb_q, rgb_d;
    logic     hsync_q, hsync_d;
    logic     vsync_q, vsync_d;
    logic     underflow_q, underflow_d;

    always_comb begin
        rgb_d = '0;
        if (act_d1_q && fifo.fifo_valid) begin
            rgb_d = rgb565_to_vga(fifo.fifo_data);
        end
        hsync_d = hs_d1_q ~^ SYNC_POL;
        vsync_d = vs_d1_q ~^ SYNC_POL;

        // A starved pixel in the same cycle as a clear must still be reported.
        underflow_d = underflow_q;
        if (clr_underflow) begin
            underflow_d = 1'b0;
        end
        if (act_d1_q && !fifo.fifo_valid) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge half_clk or posedge rst) begin
        if (rst) begin
            act_d1_q    <= 1'b0;
            hs_d1_q     <= 1'b0;
            vs_d1_q     <= 1'b0;
            rgb_q       <= '0;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            underflow_q <= 1'b0;
        end else begin
            act_d1_q    <= rd_en;
            hs_d1_q     <= hs_raw;
            vs_d1_q     <= vs_raw;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            underflow_q <= underflow_d;
        end
    end

    assign vga_red   = rgb_q.r;
    assign vga_green = rgb_q.g;
    assign vga_blue  = rgb_q.b;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Randomised scoreboard bench for vga_scan_out on a shrunk raster.
// A linear pixel-position model predicts strobes and sync; a model FIFO queues expected pixels.
`timescale 1ns/1ps
module tb_vga_scan_out;
    import vga_pkg::*;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam bit SP = 1'b0;

    logic half_clk = 1'b0;
    logic rst;
    logic en;
    logic clr_underflow;
    logic frame_start, line_req, hsync, vsync, underflow;
    logic [VGA_R_W-1:0] vga_red;
    logic [VGA_G_W-1:0] vga_green;
    logic [VGA_B_W-1:0] vga_blue;

    vga_scan_out_if fifo_if ();

    vga_scan_out #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (SP)
    ) dut (
        .half_clk      (half_clk),
        .rst           (rst),
        .en            (en),
        .fifo          (fifo_if),
        .frame_start   (frame_start),
        .line_req      (line_req),
        .hsync         (hsync),
        .vsync         (vsync),
        .vga_red       (vga_red),
        .vga_green     (vga_green),
        .vga_blue      (vga_blue),
        .underflow     (underflow),
        .clr_underflow (clr_underflow)
    );

    always #5 half_clk = ~half_clk;

    typedef struct {
        int cyc;
        int r;
        int g;
        int b;
        bit uf;
    } px_exp_t;

    px_exp_t     sb_q[$];
    logic [15:0] fifo_q[$];
    logic [15:0] nxt_data;
    logic        nxt_valid;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int pos, pos_d1, pos_d2;
    bit enq_m, en_seen, clr_seen, uf_m;
    int cur_h, cur_v;
    bit cur_en;
    int withhold_req = 0;
    int withhold_done = 0;
    bit full_frame, lat_done;
    int lr_cnt, pop_cnt, en_start;

    function automatic int exp_hsync(int p);
        int h = p % HT;
        return (h >= HA + HF && h < HA + HF + HS) ? int'(SP) : int'(!SP);
    endfunction

    function automatic int exp_vsync(int p);
        int v = p / HT;
        return (v >= VA + VF && v < VA + VF + VS) ? int'(SP) : int'(!SP);
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, want);
        end
    endtask

    task automatic reset_model();
        pos = VA * HT;
        pos_d1 = pos;
        pos_d2 = pos;
        enq_m = 1'b0;
        en_seen = 1'b0;
        clr_seen = 1'b0;
        uf_m = 1'b0;
        fifo_q.delete();
        sb_q.delete();
        nxt_valid = 1'b0;
        full_frame = 1'b0;
        lat_done = 1'b0;
        lr_cnt = 0;
        pop_cnt = 0;
        en_start = -1;
        cur_h = 0;
        cur_v = VA;
        cur_en = 1'b0;
    endtask

    task automatic check_reset_pins();
        chk("rst_fifo_rd_en", int'(fifo_if.fifo_rd_en), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_line_req", int'(line_req), 0);
        chk("rst_hsync", int'(hsync), int'(!SP));
        chk("rst_vsync", int'(vsync), int'(!SP));
        chk("rst_rgb", int'({vga_red, vga_green, vga_blue}), 0);
        chk("rst_underflow", int'(underflow), 0);
    endtask

    task automatic model_cycle();
        int h, v;
        bit rd_e, fs_e, lr_e, ok;
        px_exp_t e;
        logic [15:0] w;

        pos_d2 = pos_d1;
        pos_d1 = pos;
        if (enq_m) pos = (pos + 1) % FRAME;
        enq_m = en_seen;
        h = pos % HT;
        v = pos / HT;
        cur_h = h;
        cur_v = v;
        cur_en = enq_m;

        rd_e = enq_m && h < HA && v < VA;
        fs_e = enq_m && h == 0 && v == VA;
        lr_e = enq_m && h == HA && (v == VT - 1 || v < VA - 1);
        chk("fifo_rd_en", int'(fifo_if.fifo_rd_en), int'(rd_e));
        chk("frame_start", int'(frame_start), int'(fs_e));
        chk("line_req", int'(line_req), int'(lr_e));
        chk("hsync", int'(hsync), exp_hsync(pos_d2));
        chk("vsync", int'(vsync), exp_vsync(pos_d2));

        e.cyc = cyc; e.r = 0; e.g = 0; e.b = 0; e.uf = 1'b0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) e = sb_q.pop_front();
        if (e.uf) uf_m = 1'b1;
        else if (clr_seen) uf_m = 1'b0;
        chk("vga_red", int'(vga_red), e.r);
        chk("vga_green", int'(vga_green), e.g);
        chk("vga_blue", int'(vga_blue), e.b);
        chk("underflow", int'(underflow), int'(uf_m));

        if (fs_e) begin
            if (full_frame) begin
                chk("line_req_per_frame", lr_cnt, VA);
                chk("pops_per_frame", pop_cnt, HA * VA);
            end
            full_frame = 1'b1;
            lr_cnt = 0;
            pop_cnt = 0;
            if (en_start < 0) en_start = cyc;
        end
        if (lr_e) begin
            lr_cnt++;
            for (int i = 0; i < HA; i++) begin
                w = (i == 0) ? 16'hF800 : 16'($urandom);
                fifo_q.push_back(w);
            end
        end

        if (fifo_if.fifo_rd_en === 1'b1) begin
            pop_cnt++;
            if (!lat_done && en_start >= 0) begin
                chk("first_read_latency", cyc - en_start, (VT - VA) * HT);
                lat_done = 1'b1;
            end
            ok = fifo_q.size() > 0;
            w = ok ? fifo_q.pop_front() : 16'($urandom);
            if (withhold_req != withhold_done) begin
                ok = 1'b0;
                withhold_done++;
            end
            nxt_data = w;
            nxt_valid = ok;
            e.cyc = cyc + 2;
            e.r = ok ? int'(w[15:13]) : 0;
            e.g = ok ? int'(w[10:8]) : 0;
            e.b = ok ? int'(w[4:3]) : 0;
            e.uf = !ok;
            sb_q.push_back(e);
        end else begin
            nxt_valid = 1'b0;
            nxt_data = 16'($urandom);
        end

        clr_seen = clr_underflow;
        en_seen = en;
    endtask

    // Monitor and reference model: everything is sampled mid-cycle on the falling edge.
    initial begin
        nxt_data = '0;
        reset_model();
        forever begin
            @(negedge half_clk);
            cyc++;
            if (rst) begin
                reset_model();
                check_reset_pins();
            end else begin
                model_cycle();
            end
        end
    end

    // Model FIFO output port: one-cycle read latency after the rising edge.
    initial begin
        forever begin
            @(posedge half_clk);
            #1;
            fifo_if.fifo_data = nxt_data;
            fifo_if.fifo_valid = nxt_valid;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge half_clk);
            #1;
        end
    endtask

    task automatic wait_at(input int h, input int v);
        int budget = 3 * FRAME;
        while (!(cur_en && cur_h == h && cur_v == v)) begin
            if (budget == 0) begin
                $display("FAIL wait_at: position h=%0d v=%0d never reached, at h=%0d v=%0d", h, v, cur_h, cur_v);
                $fatal(1, "scan position timeout");
            end
            budget--;
            step(1);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        clr_underflow = 1'b0;
        step(4);
        rst = 1'b0;
        en = 1'b1;
        step(2 * FRAME + 7);

        wait_at(5, 2);
        withhold_req++;
        step(HT);
        clr_underflow = 1'b1;
        step(1);
        clr_underflow = 1'b0;
        step(HT);

        wait_at(7, 3);
        en = 1'b0;
        step(20);
        en = 1'b1;
        step(FRAME);

        wait_at(5, 3);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2 * FRAME + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
